// File: rtl/pc_gen.sv
// Program counter generator: boot/run/halt sequencing, redirect alignment,
// and deferred redirects that are captured while halted and applied on resume.
module pc_gen #(
  parameter int                  BUSWIDTH     = 32,
  parameter logic [BUSWIDTH-1:0] CPURESETADDR = 32'h0000_0000,
  parameter int                  HOLD_WIDTH   = 3,
  parameter int                  C_EXT        = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  jtag_reset_flag,
  input  logic                  jtag_halt_req,
  input  logic                  trap_flag,
  input  logic [BUSWIDTH-1:0]   trap_addr,
  input  logic                  jump_flag,
  input  logic [BUSWIDTH-1:0]   jump_addr,
  input  logic [HOLD_WIDTH-1:0] hold_flag,
  input  logic                  inst_compressed,
  input  logic                  fetch_ready,
  output logic [BUSWIDTH-1:0]   pc_address,
  output logic                  fetch_valid,
  output logic                  pc_misaligned,
  output logic                  halted,
  output logic                  redirect_pending
);

  // state | meaning
  // BOOT  | one idle cycle after reset, no fetch issued
  // RUN   | fetching; pc advances on handshake or redirect
  // HALT  | debug halt; pc frozen, redirects are parked in pend_addr
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  // Bits that must be zero in a legal target: bit0 always, bit1 without C support.
  localparam logic [BUSWIDTH-1:0] ALIGN_MASK =
    (C_EXT == 1) ? BUSWIDTH'(1) : BUSWIDTH'(3);

  state_t              state;
  logic [BUSWIDTH-1:0] pend_addr;
  logic                redirect;
  logic                stall;
  logic [BUSWIDTH-1:0] target;
  logic [BUSWIDTH-1:0] step;
  logic                resume_load;
  logic [BUSWIDTH-1:0] resume_addr;

  assign redirect    = trap_flag | jump_flag;
  assign target      = trap_flag ? trap_addr : jump_addr;
  assign stall       = |hold_flag;
  assign step        = (C_EXT == 1 && inst_compressed) ? BUSWIDTH'(2) : BUSWIDTH'(4);
  // A redirect arriving in the resume cycle itself is newer than the parked one.
  assign resume_load = redirect | redirect_pending;
  assign resume_addr = redirect ? target : pend_addr;

  assign fetch_valid = (state == RUN) && !stall;
  assign halted      = (state == HALT);

  always_ff @(posedge clk) begin
    if (!rst || jtag_reset_flag) begin
      state            <= BOOT;
      pc_address       <= CPURESETADDR;
      pend_addr        <= '0;
      redirect_pending <= 1'b0;
      pc_misaligned    <= 1'b0;
    end else begin
      pc_misaligned <= 1'b0;
      case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (redirect) begin
            pc_address    <= target & ~ALIGN_MASK;
            pc_misaligned <= |(target & ALIGN_MASK);
          end else if (fetch_valid && fetch_ready) begin
            pc_address <= pc_address + step;
          end
          if (jtag_halt_req) state <= HALT;
        end
        HALT: begin
          if (!jtag_halt_req) begin
            state            <= RUN;
            redirect_pending <= 1'b0;
            if (resume_load) begin
              pc_address    <= resume_addr & ~ALIGN_MASK;
              pc_misaligned <= |(resume_addr & ALIGN_MASK);
            end
          end else if (redirect) begin
            pend_addr        <= target;
            redirect_pending <= 1'b1;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule
